dct_block_sequencer: RTL and testbench
======================================

Name: dct_block_sequencer

Overview:
- Sequences one 8x8 block of IEEE-754 single-precision samples through a shared 1-D 8-point DCT engine: a row pass, a transpose, then a column pass.
- Sits between the block source (row stream) and the existing multi-stage 1-D DCT pipeline, which has an en input and a valid output.
- Owns the 8x8 transpose buffer and drives the engine's enable and input vector.
- Emits the 2-D result as eight column vectors.

Parameters:
- W, 32, word width in bits (float32).
- N, 8, vector length and block dimension (only 8 supported).
- TIMEOUT, 64, maximum idle cycles in a drain state before an error abort.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input row present.
- in_ready  out  1  row accepted when in_valid && in_ready.
- in_row  in  N*W  row; word k at [32k+31:32k] (word 0 = N0).
- dct_en  out  1  engine enable.
- dct_in_valid  out  1  dct_in carries a vector to process this cycle.
- dct_in  out  N*W  vector to engine, same packing.
- dct_res_valid  in  1  engine result present (one cycle per result).
- dct_res  in  N*W  engine result vector.
- out_valid  out  1  out_vec valid (one-cycle pulse per column).
- out_col_idx  out  3  column index of out_vec.
- out_vec  out  N*W  column-pass result (passthrough of dct_res).
- done  out  1  one-cycle pulse, concurrent with 8th out_valid.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, reset=0):
  - state = IDLE; all counters = 0.
  - dct_in = 0; dct_in_valid = 0; err = 0; done = 0.
  - buffer contents are don't-care.
- States: IDLE, ROW_FEED, ROW_DRAIN, COL_FEED, COL_DRAIN.
- in_ready = 1 in IDLE and ROW_FEED, else 0. dct_en = busy.
- Row accept:
  - Each accepted row is registered into dct_in; dct_in_valid is high the next cycle (1-cycle issue latency).
  - An accept in IDLE is row 0 and moves the state to ROW_FEED.
  - The 8th accept moves ROW_FEED to ROW_DRAIN.
  - Gaps in in_valid are allowed and simply stall the feed.
- Row results:
  - Counted in ROW_FEED and ROW_DRAIN.
  - Result r (0..7, arrival order) is written to buffer row r.
  - When the 8th result arrives, next state = COL_FEED.
- COL_FEED:
  - Lasts exactly 8 cycles; in cycle c, column c is loaded into dct_in, with word k = buf[k] word c.
  - dct_in_valid is high the following cycle.
  - After cycle 7, state = COL_DRAIN.
- Column results:
  - Counted in COL_FEED and COL_DRAIN.
  - Each result sets out_valid = 1 combinationally, with out_vec = dct_res and out_col_idx = result count.
  - On the 8th result, done = 1 in the same cycle and next state = IDLE.
  - There is no output backpressure; the consumer must accept every out_valid.
- Ignored results: dct_res_valid in IDLE, and any result beyond 8 in a pass, are ignored (no buffer write, no out_valid).
- dct_in_valid is 0 in every cycle that does not follow an issue. dct_in holds its last value.
- Timeout:
  - In ROW_DRAIN or COL_DRAIN, a cycle counter increments on each cycle without dct_res_valid and clears on each result and on state entry.
  - When it reaches TIMEOUT: err = 1 for one cycle, next state = IDLE, all counters cleared, no done.
- Reset mid-block: immediate return to IDLE; the partial block is discarded and no done is produced.
- Back-to-back blocks: in_ready is high again in the cycle after done.
- Arithmetic: none on data. Counters are 3-bit plus a terminal flag; the timeout counter is clog2(TIMEOUT+1) bits.

Test Plan:
- Stub engine (identity, latency 3 from dct_in_valid); in_valid held high; row r word k = r*8+k. Required response:
  - rows accepted cycles 0–7; dct_in_valid cycles 1–8;
  - row results cycles 4–11; COL_FEED cycles 12–19; dct_in_valid 13–20;
  - out_valid cycles 16–23 with out_col_idx 0..7; column 2 word 5 = 0x2A;
  - done at cycle 23; busy=0 and in_ready=1 at cycle 24.
- Float data, identity engine: row 0 = 1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 7.0, 8.0 (0x3F800000 … 0x41000000), other rows 0. Required response: out column c word 0 = float(c+1); all other words 0.
- in_valid toggled 1/0 every cycle. Required response: 8 accepts over 15 cycles; each dct_in_valid exactly one cycle after its accept; output identical to the first scenario.
- Engine stub withholds the 6th row result. Required response: err pulse exactly TIMEOUT cycles after the 5th result; busy=0 next cycle; no out_valid and no done.
- reset=0 asserted during COL_FEED column 3. Required response: all outputs 0 and in_ready=1 asynchronously; a subsequent full block completes normally.
- Spurious dct_res_valid in IDLE, plus a 9th result during COL_DRAIN of a padded stub. Required response: both ignored; exactly 8 out_valid and 1 done.

Source files
------------

// File: rtl/dct_block_sequencer_if.sv
// Handshake and data bus between the block source, the shared 1-D DCT engine,
// the column-result consumer and the sequencer.
interface dct_block_sequencer_if #(
  parameter int W = 32,
  parameter int N = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*W-1:0]         in_row;
  logic                   dct_en;
  logic                   dct_in_valid;
  logic [N*W-1:0]         dct_in;
  logic                   dct_res_valid;
  logic [N*W-1:0]         dct_res;
  logic                   out_valid;
  logic [$clog2(N)-1:0]   out_col_idx;
  logic [N*W-1:0]         out_vec;
  logic                   done;
  logic                   busy;
  logic                   err;

  modport slave (
    input  in_valid, in_row, dct_res_valid, dct_res,
    output in_ready, dct_en, dct_in_valid, dct_in,
           out_valid, out_col_idx, out_vec, done, busy, err
  );

  modport master (
    output in_valid, in_row, dct_res_valid, dct_res,
    input  in_ready, dct_en, dct_in_valid, dct_in,
           out_valid, out_col_idx, out_vec, done, busy, err
  );
endinterface

// File: rtl/dct_block_sequencer.sv
// Runs one 8x8 block through a shared 1-D DCT engine: row pass, transpose
// buffer, column pass, with a drain timeout that aborts a stalled block.
//
// state     | meaning
// IDLE      | waiting for row 0; in_ready high
// ROW_FEED  | accepting rows 1..7 and issuing them; row results may arrive
// ROW_DRAIN | all rows issued, waiting for the remaining row results
// COL_FEED  | issuing one buffer column per cycle, 8 cycles
// COL_DRAIN | all columns issued, waiting for the remaining column results
module dct_block_sequencer #(
  parameter int W       = 32,
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  dct_block_sequencer_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ROW_FEED,
    ROW_DRAIN,
    COL_FEED,
    COL_DRAIN
  } state_t;

  state_t          state;
  logic [CW-1:0]   acc_cnt;
  logic [CW-1:0]   res_cnt;
  logic [CW-1:0]   feed_cnt;
  logic [TW-1:0]   tmr;
  logic [N*W-1:0]  dct_in_q;
  logic            dct_in_valid_q;
  logic [W-1:0]    tbuf [N][N];
  logic [N*W-1:0]  col_vec;

  logic in_ready;
  logic accept;
  logic row_res;
  logic col_res;
  logic drain;
  logic timeout;
  logic blk_done;

  assign in_ready = (state == IDLE) || (state == ROW_FEED);
  assign accept   = bus.in_valid && in_ready;
  assign row_res  = bus.dct_res_valid && ((state == ROW_FEED) || (state == ROW_DRAIN));
  assign col_res  = bus.dct_res_valid && ((state == COL_FEED) || (state == COL_DRAIN));
  assign drain    = (state == ROW_DRAIN) || (state == COL_DRAIN);
  // The timer "reaches TIMEOUT" on the edge that ends this cycle.
  assign timeout  = drain && !bus.dct_res_valid && (tmr == TLAST);
  assign blk_done = col_res && (res_cnt == LAST);

  // Column c of the buffer: word k comes from buffered row k.
  always_comb begin
    col_vec = '0;
    for (int k = 0; k < N; k++) begin
      col_vec[k*W +: W] = tbuf[k][feed_cnt];
    end
  end

  // Transpose storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (row_res) begin
      for (int k = 0; k < N; k++) begin
        tbuf[res_cnt][k] <= bus.dct_res[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      acc_cnt        <= '0;
      res_cnt        <= '0;
      feed_cnt       <= '0;
      tmr            <= '0;
      dct_in_q       <= '0;
      dct_in_valid_q <= 1'b0;
    end else begin
      dct_in_valid_q <= 1'b0;
      if (accept) begin
        dct_in_q       <= bus.in_row;
        dct_in_valid_q <= 1'b1;
      end
      if (state == COL_FEED) begin
        dct_in_q       <= col_vec;
        dct_in_valid_q <= 1'b1;
      end

      if (drain && !bus.dct_res_valid) begin
        tmr <= tmr + TW'(1);
      end else begin
        tmr <= '0;
      end

      // One result counter serves both passes; it wraps to 0 at each pass end.
      if (row_res || col_res) begin
        res_cnt <= res_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            acc_cnt <= CW'(1);
            state   <= ROW_FEED;
          end
        end
        ROW_FEED: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
          end
          if (row_res && (res_cnt == LAST)) begin
            acc_cnt <= '0;
            state   <= COL_FEED;
          end else if (accept && (acc_cnt == LAST)) begin
            state <= ROW_DRAIN;
          end
        end
        ROW_DRAIN: begin
          if (row_res && (res_cnt == LAST)) begin
            state <= COL_FEED;
          end
        end
        COL_FEED: begin
          feed_cnt <= feed_cnt + 1'b1;
          if (feed_cnt == LAST) begin
            state <= COL_DRAIN;
          end
        end
        COL_DRAIN: begin
        end
        default: state <= IDLE;
      endcase

      // Block end (normal or abort) overrides whatever the state arms chose.
      if (timeout || blk_done) begin
        state    <= IDLE;
        acc_cnt  <= '0;
        res_cnt  <= '0;
        feed_cnt <= '0;
        tmr      <= '0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state != IDLE);
  assign bus.dct_en       = (state != IDLE);
  assign bus.dct_in       = dct_in_q;
  assign bus.dct_in_valid = dct_in_valid_q;
  assign bus.out_valid    = col_res;
  assign bus.out_col_idx  = col_res ? res_cnt : '0;
  assign bus.out_vec      = col_res ? bus.dct_res : '0;
  assign bus.done         = blk_done;
  assign bus.err          = timeout;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed + randomized bench: identity engine stub with latency 3, reference
// model is a plain 8x8 transpose of the accepted rows.
module tb_dct_block_sequencer;
  localparam int W = 32;
  localparam int N = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dct_block_sequencer_if #(.W(W), .N(N)) bus ();
  dct_block_sequencer #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [N*W-1:0] rows [N];
  logic [31:0]    fl [N];

  // engine stub state
  logic           pv [4];
  logic [N*W-1:0] pd [4];
  int  emitted;
  int  stop_after;
  bit  pad_extra;
  bit  extra_pending;
  bit  spur;

  // event logs
  int             acc_t[$];
  int             iv_t[$];
  logic [N*W-1:0] iv_v[$];
  int             ov_t[$];
  int             ov_i[$];
  logic [N*W-1:0] ov_v[$];
  int             done_t[$];
  int             err_t[$];
  int             res_t[$];
  logic           last_busy;
  logic           last_ready;

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
    return v;
  endfunction

  function automatic logic [N*W-1:0] col_of(input int c);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = rows[k][c*W +: W];
    return v;
  endfunction

  task automatic engine_step();
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = bus.dct_in_valid;
    pd[0] = bus.dct_in;
    bus.dct_res_valid = 1'b0;
    bus.dct_res = '0;
    if (pv[3] && (stop_after == 0 || emitted < stop_after)) begin
      bus.dct_res_valid = 1'b1;
      bus.dct_res = pd[3];
      emitted++;
      res_t.push_back(cyc);
      if (pad_extra && emitted == 2*N) extra_pending = 1'b1;
    end else if (extra_pending) begin
      bus.dct_res_valid = 1'b1;
      bus.dct_res = rand_vec();
      extra_pending = 1'b0;
    end
    if (spur) begin
      bus.dct_res_valid = 1'b1;
      bus.dct_res = rand_vec();
    end
  endtask

  task automatic cycle(input logic iv, input logic [N*W-1:0] row);
    @(posedge clk);
    #1;
    cyc++;
    engine_step();
    bus.in_valid = iv;
    bus.in_row = row;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) acc_t.push_back(cyc);
    if (bus.dct_in_valid) begin
      iv_t.push_back(cyc);
      iv_v.push_back(bus.dct_in);
    end
    if (bus.out_valid) begin
      ov_t.push_back(cyc);
      ov_i.push_back(int'(bus.out_col_idx));
      ov_v.push_back(bus.out_vec);
    end
    if (bus.done) done_t.push_back(cyc);
    if (bus.err) err_t.push_back(cyc);
    last_busy = bus.busy;
    last_ready = bus.in_ready;
  endtask

  task automatic clear_logs();
    acc_t.delete(); iv_t.delete(); iv_v.delete(); ov_t.delete(); ov_i.delete();
    ov_v.delete(); done_t.delete(); err_t.delete(); res_t.delete();
    emitted = 0;
    extra_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  // mode 0: in_valid held high, 1: toggled 1/0, 2: random gaps
  task automatic run_block(input int mode, input int abort_rel, output int t0);
    int  n;
    bit  fin;
    logic v;
    n = 0; fin = 1'b0; t0 = -1;
    for (int i = 0; i < 400 && !fin; i++) begin
      case (mode)
        0: v = 1'b1;
        1: v = (i % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (n >= N) v = 1'b0;
      cycle(v, rows[(n < N) ? n : 0]);
      if (acc_t.size() > n) begin
        if (n == 0) t0 = acc_t[0];
        n++;
      end
      if (done_t.size() > 0 || err_t.size() > 0) fin = 1'b1;
      if (abort_rel >= 0 && t0 >= 0 && cyc - t0 == abort_rel) return;
    end
    chk("block_finished", N*W'(fin), N*W'(1));
    cycle(1'b0, '0);
  endtask

  task automatic check_block(input string nm);
    chk({nm, "_accepts"}, acc_t.size(), N);
    chk({nm, "_issues"}, iv_t.size(), 2*N);
    for (int k = 0; k < 2*N && k < iv_v.size(); k++)
      chk($sformatf("%s_issue%0d", nm, k), iv_v[k], (k < N) ? rows[k] : col_of(k - N));
    for (int k = 0; k < N && k < acc_t.size() && k < iv_t.size(); k++)
      chk($sformatf("%s_issue_lat%0d", nm, k), iv_t[k], acc_t[k] + 1);
    chk({nm, "_outs"}, ov_t.size(), N);
    for (int c = 0; c < N && c < ov_v.size(); c++) begin
      chk($sformatf("%s_col_idx%0d", nm, c), ov_i[c], c);
      chk($sformatf("%s_col%0d", nm, c), ov_v[c], col_of(c));
    end
    chk({nm, "_done_n"}, done_t.size(), 1);
    if (done_t.size() > 0 && ov_t.size() == N)
      chk({nm, "_done_t"}, done_t[0], ov_t[N-1]);
    chk({nm, "_err_n"}, err_t.size(), 0);
    chk({nm, "_busy_after"}, last_busy, 0);
    chk({nm, "_ready_after"}, last_ready, 1);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_dct_en"}, bus.dct_en, 0);
    chk({nm, "_dct_in_valid"}, bus.dct_in_valid, 0);
    chk({nm, "_dct_in"}, bus.dct_in, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_vec"}, bus.out_vec, 0);
    chk({nm, "_out_col_idx"}, bus.out_col_idx, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_err"}, bus.err, 0);
  endtask

  initial begin
    int t0;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.dct_res_valid = 1'b0;
    bus.dct_res = '0;
    stop_after = 0; pad_extra = 1'b0; spur = 1'b0;
    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    clear_logs();

    #12;
    check_quiet("reset");
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // 1: counting pattern, in_valid held high, exact timing
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) rows[r][k*W +: W] = 32'(r*8 + k);
    clear_logs();
    run_block(0, -1, t0);
    check_block("seq");
    for (int k = 0; k < N && k < acc_t.size(); k++)
      chk($sformatf("seq_acc_t%0d", k), acc_t[k] - t0, k);
    for (int k = 0; k < 2*N && k < iv_t.size(); k++)
      chk($sformatf("seq_iv_t%0d", k), iv_t[k] - t0, (k < N) ? k + 1 : k + 5);
    for (int c = 0; c < N && c < ov_t.size(); c++)
      chk($sformatf("seq_ov_t%0d", c), ov_t[c] - t0, 16 + c);
    if (ov_v.size() > 2) chk("seq_col2_word5", ov_v[2][5*W +: W], 32'h2A);
    if (done_t.size() > 0) chk("seq_done_cycle", done_t[0] - t0, 23);
    chk("seq_idle_cycle", cyc - t0, 24);
    idle(2);

    // 2: float row 0, identity engine
    for (int r = 0; r < N; r++) rows[r] = '0;
    for (int k = 0; k < N; k++) rows[0][k*W +: W] = fl[k];
    clear_logs();
    run_block(0, -1, t0);
    check_block("float");
    for (int c = 0; c < N && c < ov_v.size(); c++)
      chk($sformatf("float_w0_col%0d", c), ov_v[c][0 +: W], fl[c]);
    idle(2);

    // 3: toggled in_valid, counting pattern again
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) rows[r][k*W +: W] = 32'(r*8 + k);
    clear_logs();
    run_block(1, -1, t0);
    check_block("toggle");
    if (acc_t.size() == N) chk("toggle_span", acc_t[N-1] - acc_t[0], 14);
    idle(2);

    // 4: engine withholds the 6th row result onward
    for (int r = 0; r < N; r++) rows[r] = rand_vec();
    clear_logs();
    stop_after = 5;
    run_block(0, -1, t0);
    stop_after = 0;
    chk("to_err_n", err_t.size(), 1);
    if (err_t.size() > 0 && res_t.size() >= 5) begin
      chk("to_err_t", err_t[0], res_t[4] + TIMEOUT);
      chk("to_err_rel", err_t[0] - t0, 8 + TIMEOUT);
    end
    chk("to_outs", ov_t.size(), 0);
    chk("to_done", done_t.size(), 0);
    chk("to_busy_after", last_busy, 0);
    chk("to_ready_after", last_ready, 1);
    idle(2);

    // 5: reset during COL_FEED column 3, then a normal block
    for (int r = 0; r < N; r++) rows[r] = rand_vec();
    clear_logs();
    run_block(0, 15, t0);
    chk("rst_mid_busy_before", bus.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("rst_mid");
    chk("rst_mid_no_done", done_t.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    idle(3);
    for (int r = 0; r < N; r++) rows[r] = rand_vec();
    clear_logs();
    run_block(0, -1, t0);
    check_block("after_rst");
    idle(2);

    // 6: spurious results in IDLE, then a padded stub with a 9th column result
    clear_logs();
    spur = 1'b1;
    idle(3);
    spur = 1'b0;
    chk("spur_outs", ov_t.size(), 0);
    chk("spur_busy", last_busy, 0);
    for (int r = 0; r < N; r++) rows[r] = rand_vec();
    clear_logs();
    pad_extra = 1'b1;
    run_block(0, -1, t0);
    idle(1);
    pad_extra = 1'b0;
    chk("pad_outs", ov_t.size(), N);
    chk("pad_done", done_t.size(), 1);
    idle(2);

    // 7: random data with random input gaps
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < N; r++) rows[r] = rand_vec();
      clear_logs();
      run_block(2, -1, t0);
      check_block($sformatf("rand%0d", b));
      idle(1 + b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
